// File: rtl/button_events.sv
// button_events: synchronizes, debounces and classifies push-button activity.
// Every channel runs its own FSM and emits registered one-cycle event pulses.
module button_events #(
    parameter int               N_BTN         = 5,
    parameter int               DEB_CYCLES    = 1_000_000,
    parameter int               LONG_CYCLES   = 100_000_000,
    parameter int               REPEAT_CYCLES = 25_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = 5'b00100,
    parameter int               CNT_W         = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    // release and repeat are reserved words, hence the _pulse suffix
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] short_press,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_P,
        PRESSED,
        HELD,
        DEB_R
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    // two-flop synchronizer on the raw asynchronous button levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic [CNT_W-1:0] rcnt;
        logic [CNT_W-1:0] rcnt_nxt;
        logic             long_flag;
        logic             long_flag_nxt;
        logic             s;
        logic             press_q;
        logic             release_q;
        logic             short_q;
        logic             long_q;
        logic             repeat_q;
        logic             press_d;
        logic             release_d;
        logic             short_d;
        logic             long_d;
        logic             repeat_d;

        assign s = sync2[i];

        // channel state, counters and registered event pulses
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= IDLE;
                cnt       <= '0;
                rcnt      <= '0;
                long_flag <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                short_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                rcnt      <= rcnt_nxt;
                long_flag <= long_flag_nxt;
                press_q   <= press_d;
                release_q <= release_d;
                short_q   <= short_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
            end
        end

        // next state, counter updates and event decisions
        always_comb begin
            state_nxt     = state;
            cnt_nxt       = cnt;
            rcnt_nxt      = rcnt;
            long_flag_nxt = long_flag;
            press_d       = 1'b0;
            release_d     = 1'b0;
            short_d       = 1'b0;
            long_d        = 1'b0;
            repeat_d      = 1'b0;
            unique case (state)
                IDLE: begin
                    if (s) begin
                        state_nxt = DEB_P;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                DEB_P: begin
                    if (!s) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt >= DEB_LAST) begin
                        state_nxt     = PRESSED;
                        cnt_nxt       = '0;
                        press_d       = 1'b1;
                        long_flag_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_nxt = DEB_R;
                        rcnt_nxt  = CNT_ONE;
                    end else if (cnt >= LONG_LAST) begin
                        state_nxt     = HELD;
                        cnt_nxt       = '0;
                        long_d        = 1'b1;
                        long_flag_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_nxt = DEB_R;
                        rcnt_nxt  = CNT_ONE;
                    end else if (cnt >= REP_LAST) begin
                        cnt_nxt  = '0;
                        repeat_d = REPEAT_MASK[i];
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                DEB_R: begin
                    // hold counter stays frozen so a bounce resumes timing
                    if (s) begin
                        state_nxt = long_flag ? HELD : PRESSED;
                        rcnt_nxt  = '0;
                    end else if (rcnt >= DEB_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        rcnt_nxt  = '0;
                        release_d = 1'b1;
                        short_d   = ~long_flag;
                    end else begin
                        rcnt_nxt = rcnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rcnt_nxt  = '0;
                end
            endcase
        end

        assign level[i]         = (state == PRESSED) ||
                                  (state == HELD) ||
                                  (state == DEB_R);
        assign press[i]         = press_q;
        assign release_pulse[i] = release_q;
        assign short_press[i]   = short_q;
        assign long_press[i]    = long_q;
        assign repeat_pulse[i]  = repeat_q;
    end

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed stimulus against a run-length model of the
// button channels, checked every cycle, plus hand-computed timing checks.
module tb_button_events;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 8;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] btn_raw = '0;
    logic [4:0] level;
    logic [4:0] press;
    logic [4:0] release_pulse;
    logic [4:0] short_press;
    logic [4:0] long_press;
    logic [4:0] repeat_pulse;

    button_events #(
        .N_BTN        (5),
        .DEB_CYCLES   (DEB),
        .LONG_CYCLES  (LNG),
        .REPEAT_CYCLES(REP),
        .REPEAT_MASK  (5'b00100),
        .CNT_W        (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_raw      (btn_raw),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    logic [4:0] mask_v = 5'b00100;

    // model: sync delay line, run lengths of samples, hold-time count
    logic [4:0] ms1, ms2, m_s;
    logic [4:0] e_level, e_press, e_rel, e_short, e_long, e_rep;
    int  ones[5];
    int  zeros[5];
    int  adv[5];
    bit  prev_s[5];
    bit  long_seen[5];

    // observed pulse statistics
    int cnt_press[5];
    int cnt_rel[5];
    int cnt_short[5];
    int cnt_long[5];
    int cnt_rep[5];
    int last_press[5];
    int last_long[5];
    int last_rep[5];
    int prev_rep[5];

    int rep0;
    int rel0;

    task automatic model_reset();
        ms1 = '0; ms2 = '0;
        e_level = '0; e_press = '0; e_rel = '0;
        e_short = '0; e_long = '0; e_rep = '0;
        for (int i = 0; i < 5; i++) begin
            ones[i] = 0; zeros[i] = 0; adv[i] = 0;
            prev_s[i] = 1'b0; long_seen[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        m_s = ms2;
        e_press = '0; e_rel = '0; e_short = '0;
        e_long = '0; e_rep = '0;
        for (int i = 0; i < 5; i++) begin
            if (m_s[i]) begin
                ones[i]++; zeros[i] = 0;
            end else begin
                zeros[i]++; ones[i] = 0;
            end
            if (!e_level[i]) begin
                if (ones[i] == DEB) begin
                    e_level[i] = 1'b1; e_press[i] = 1'b1;
                    adv[i] = 0; long_seen[i] = 1'b0;
                end
            end else if (zeros[i] == DEB) begin
                e_level[i] = 1'b0; e_rel[i] = 1'b1;
                e_short[i] = !long_seen[i];
            end else if (m_s[i] && prev_s[i]) begin
                adv[i]++;
                if (adv[i] == LNG) begin
                    e_long[i] = 1'b1; long_seen[i] = 1'b1;
                end else if (adv[i] > LNG && ((adv[i] - LNG) % REP) == 0) begin
                    e_rep[i] = mask_v[i];
                end
            end
            prev_s[i] = m_s[i];
        end
        ms2 = ms1;
        ms1 = btn_raw;
    endtask

    task automatic compare_cycle();
        ncyc++;
        total++;
        if ({level, press, release_pulse, short_press, long_press, repeat_pulse} !==
            {e_level, e_press, e_rel, e_short, e_long, e_rep}) begin
            bad++;
            $display("FAIL cycle_cmp cyc=%0d got lvl=%b p=%b r=%b s=%b l=%b rp=%b want lvl=%b p=%b r=%b s=%b l=%b rp=%b",
                     ncyc, level, press, release_pulse, short_press, long_press,
                     repeat_pulse, e_level, e_press, e_rel, e_short, e_long, e_rep);
        end
        for (int i = 0; i < 5; i++) begin
            if (press[i] === 1'b1) begin
                cnt_press[i]++; last_press[i] = ncyc;
            end
            if (release_pulse[i] === 1'b1) cnt_rel[i]++;
            if (short_press[i] === 1'b1) cnt_short[i]++;
            if (long_press[i] === 1'b1) begin
                cnt_long[i]++; last_long[i] = ncyc;
            end
            if (repeat_pulse[i] === 1'b1) begin
                cnt_rep[i]++; prev_rep[i] = last_rep[i]; last_rep[i] = ncyc;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 5; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_short[i] = 0;
            cnt_long[i] = 0; cnt_rep[i] = 0; last_press[i] = 0;
            last_long[i] = 0; last_rep[i] = 0; prev_rep[i] = 0;
        end
        fork
            forever begin
                @(posedge clk or negedge reset_n);
                if (!reset_n) model_reset();
                else model_step();
            end
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // reset state
        cyc(3);
        check("reset_outputs",
              32'({level, press, release_pulse, short_press, long_press, repeat_pulse}),
              32'd0);
        reset_n = 1'b1;
        cyc(2);

        // clean short press on ch0, held 10 cycles
        btn_raw[0] = 1'b1;
        cyc(5);
        check("c0_press_early", 32'(press[0]), 32'd0);
        cyc(1);
        check("c0_press", 32'(press[0]), 32'd1);
        check("c0_level", 32'(level[0]), 32'd1);
        cyc(4);
        btn_raw[0] = 1'b0;
        cyc(5);
        check("c0_release_early", 32'(release_pulse[0]), 32'd0);
        cyc(1);
        check("c0_release", 32'(release_pulse[0]), 32'd1);
        check("c0_short", 32'(short_press[0]), 32'd1);
        cyc(3);
        check("c0_short_count", 32'(cnt_short[0]), 32'd1);
        check("c0_no_long", 32'(cnt_long[0]), 32'd0);

        // bounce on ch1 shorter than the debounce window
        btn_raw[1] = 1'b1;
        cyc(3);
        btn_raw[1] = 1'b0;
        cyc(10);
        check("c1_no_press", 32'(cnt_press[1]), 32'd0);
        check("c1_level", 32'(level[1]), 32'd0);

        // long hold on ch2 with auto-repeat
        btn_raw[2] = 1'b1;
        cyc(60);
        btn_raw[2] = 1'b0;
        cyc(10);
        check("c2_press", 32'(cnt_press[2]), 32'd1);
        check("c2_long", 32'(cnt_long[2]), 32'd1);
        check("c2_long_delay", 32'(last_long[2] - last_press[2]), 32'd20);
        check("c2_repeats", 32'(cnt_rep[2]), 32'd4);
        check("c2_rep_period", 32'(last_rep[2] - prev_rep[2]), 32'd8);
        check("c2_release", 32'(cnt_rel[2]), 32'd1);
        check("c2_no_short", 32'(cnt_short[2]), 32'd0);

        // long hold on ch3, repeat masked off
        btn_raw[3] = 1'b1;
        cyc(60);
        btn_raw[3] = 1'b0;
        cyc(10);
        check("c3_long", 32'(cnt_long[3]), 32'd1);
        check("c3_no_repeat", 32'(cnt_rep[3]), 32'd0);
        check("c3_no_short", 32'(cnt_short[3]), 32'd0);

        // simultaneous presses on ch0 and ch4
        btn_raw = 5'b10001;
        cyc(6);
        check("c04_press", 32'(press), 32'h11);
        btn_raw = '0;
        cyc(10);

        // reset in the middle of a press on ch0
        rep0 = cnt_rep[2];
        btn_raw[0] = 1'b1;
        cyc(10);
        rel0 = cnt_rel[0];
        #2 reset_n = 1'b0;
        #1 check("rst_immediate",
                 32'({level, press, release_pulse, short_press, long_press, repeat_pulse}),
                 32'd0);
        cyc(3);
        check("rst_hold",
              32'({level, press, release_pulse, short_press, long_press, repeat_pulse}),
              32'd0);
        reset_n = 1'b1;
        cyc(5);
        check("rst_press_early", 32'(press[0]), 32'd0);
        cyc(1);
        check("rst_repress", 32'(press[0]), 32'd1);
        check("rst_no_release", 32'(cnt_rel[0]), 32'(rel0));
        check("rst_no_stray_rep", 32'(cnt_rep[2]), 32'(rep0));
        btn_raw = '0;
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter N_BTN, default 5, number of independent button channels (bit 0 mode, 1 edit_shift, 2 inc, 3 start_stop, 4 clear).
REQ-002 SHALL have parameter DEB_CYCLES, default 1_000_000, consecutive stable synchronized samples needed to accept a level change.
REQ-003 SHALL have parameter LONG_CYCLES, default 100_000_000, cycles in PRESSED before a long-press event.
REQ-004 SHALL have parameter REPEAT_CYCLES, default 25_000_000, auto-repeat period while in HELD.
REQ-005 SHALL have parameter REPEAT_MASK, default 5'b00100, per-channel auto-repeat enable.
REQ-006 SHALL have parameter CNT_W, default 27, width of each channel counter; it holds max(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES).
REQ-007 clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 btn_raw  input  N_BTN  raw asynchronous push-button levels, active-high.
REQ-010 level  output  N_BTN  debounced button level.
REQ-011 press  output  N_BTN  one-cycle pulse on accepted press.
REQ-012 release  output  N_BTN  one-cycle pulse on accepted release.
REQ-013 short_press  output  N_BTN  one-cycle pulse on release when no long event occurred.
REQ-014 long_press  output  N_BTN  one-cycle pulse on reaching LONG_CYCLES.
REQ-015 repeat  output  N_BTN  one-cycle auto-repeat pulse.

Function
REQ-016 Each channel SHALL pass btn_raw through a two-flop synchronizer; the second flop output s is the only value the channel FSM samples.
REQ-017 Each channel SHALL implement an independent FSM with states IDLE, DEB_P, PRESSED, HELD, DEB_R, a CNT_W counter and a long_flag bit.
REQ-018 IDLE: s=1 -> DEB_P, cnt=1; otherwise stay, cnt=0.
REQ-019 DEB_P: s=0 -> IDLE, cnt=0, no pulse; s=1 and cnt=DEB_CYCLES-1 -> PRESSED, cnt=0, press=1, long_flag=0; else cnt+1.
REQ-020 PRESSED: s=0 -> DEB_R, release counter starts at 1, hold cnt frozen; cnt=LONG_CYCLES-1 -> HELD, cnt=0, long_press=1, long_flag=1; else cnt+1.
REQ-021 HELD: s=0 -> DEB_R as in REQ-020; cnt=REPEAT_CYCLES-1 -> cnt=0, repeat=REPEAT_MASK[i]; else cnt+1.
REQ-022 DEB_R SHALL use a separate release counter: s=1 -> return to PRESSED if long_flag=0, else HELD, with hold cnt resumed unchanged; s=0 and release count=DEB_CYCLES-1 -> IDLE, release=1, short_press=~long_flag.
REQ-023 level SHALL be 1 in PRESSED, HELD and DEB_R, and 0 in IDLE and DEB_P.
REQ-024 All event outputs SHALL be registered, high for exactly one cycle per event.
REQ-025 Latency: with raw held high and sampled at edge E1, s=1 after E2, and press SHALL be high in the cycle after edge E(DEB_CYCLES+2).
REQ-026 Channels SHALL be fully independent; simultaneous presses on several channels SHALL each pulse in the same cycle.
REQ-027 A bounce shorter than DEB_CYCLES samples SHALL produce no event and no level change.
REQ-028 Counters SHALL never wrap; every terminal count forces a reload to 0 or a state change.

Reset
REQ-029 reset_n=0 SHALL immediately clear synchronizers, counters, long_flag and all outputs to 0, with every FSM in IDLE, regardless of clock.
REQ-030 Assertion of reset_n mid-press SHALL emit no release or short_press pulse.
REQ-031 A button held through reset deassertion SHALL be treated as a new press after the full synchronizer and debounce latency.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, REPEAT_MASK=5'b00100)
REQ-032 Clean press on ch0 at edge E1, released after 10 cycles -> press[0] pulse after E6; release[0] and short_press[0] single pulses; no long_press.
REQ-033 Bounce ch1 high 3 cycles, then low -> no events; level[1] stays 0.
REQ-034 Hold ch2 for 60 cycles -> press, long_press 20 cycles after press, repeat every 8 cycles thereafter; release without short_press.
REQ-035 Hold ch3 for 60 cycles -> long_press but no repeat, because mask bit 3 is 0.
REQ-036 Ch0 and ch4 pressed on the same edge -> press[0] and press[4] asserted in the same cycle.
REQ-037 Hold ch0, assert reset_n=0 mid-PRESSED for 3 cycles, then release reset with the button still held -> all outputs 0 during reset, no release pulse, new press pulse 6 cycles after reset_n rises.
